// File: rtl/poly_pkg.sv
// Shared definitions for the polynomial command path (decode and execute stages).
package poly_pkg;

    localparam int MAX_DEG  = 10;
    localparam int NUM_POLY = 8;

    localparam logic [7:0] OP_SET      = 8'd0;
    localparam logic [7:0] OP_EVAL     = 8'd1;
    localparam logic [7:0] OP_EVAL_BLK = 8'd2;
    localparam logic [7:0] OP_CLR      = 8'd3;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BAD_OP  = 2'd1;
    localparam logic [1:0] ST_BAD_DEG = 2'd2;
    localparam logic [1:0] ST_NO_POLY = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_GET_X,
        S_HORNER,
        S_EMIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/poly_coef_store.sv
// Coefficient register file with per-slot degree and valid bits.
module poly_coef_store #(
    parameter int DATA_W   = 16,
    parameter int MAX_DEG  = poly_pkg::MAX_DEG,
    parameter int NUM_POLY = poly_pkg::NUM_POLY,
    localparam int SW      = $clog2(NUM_POLY),
    localparam int DW      = $clog2(MAX_DEG + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     set_valid,
    input  logic                     inval_en,
    input  logic                     clr_all,
    input  logic [SW-1:0]            slot,
    input  logic [DW-1:0]            wr_idx,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic [DW-1:0]            set_deg,
    input  logic [SW-1:0]            rd_slot,
    input  logic [DW-1:0]            rd_idx,
    output logic signed [DATA_W-1:0] rd_coef,
    output logic [DW-1:0]            rd_deg,
    output logic [NUM_POLY-1:0]      valid
);

    logic signed [DATA_W-1:0] coef [NUM_POLY][MAX_DEG+1];
    logic [DW-1:0]            deg_mem [NUM_POLY];

    // Contents are qualified by valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            coef[slot][wr_idx] <= wr_data;
        if (set_valid)
            deg_mem[slot] <= set_deg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else if (clr_all) begin
            valid <= '0;
        end else begin
            if (inval_en)
                valid[slot] <= 1'b0;
            if (set_valid)
                valid[slot] <= 1'b1;
        end
    end

    assign rd_coef = coef[rd_slot][rd_idx];
    assign rd_deg  = deg_mem[rd_slot];

endmodule

// File: rtl/poly_cmd_exec.sv
// Command execution stage: loads polynomial slots and evaluates them by Horner's rule.
module poly_cmd_exec #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int MAX_DEG  = poly_pkg::MAX_DEG,
    parameter int NUM_POLY = poly_pkg::NUM_POLY
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start_proc,
    input  logic [7:0]               command,
    input  logic [2:0]               arg1,
    input  logic [4:0]               arg2,
    input  logic [1:0]               error_in,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               status,
    output logic                     status_valid,
    output logic                     done_proc,
    output logic                     busy
);

    import poly_pkg::*;

    localparam int DW = $clog2(MAX_DEG + 1);

    state_t                   state, state_nxt;
    logic [2:0]               slot_r;
    logic [DW-1:0]            deg_r, k_r;
    logic [4:0]               cnt_r;
    logic signed [DATA_W-1:0] x_r;
    logic signed [ACC_W-1:0]  acc_r, x_ext, coef_ext;
    logic [1:0]               st_r, st_nxt;

    logic                     wr_en, set_valid, inval_en, clr_all;
    logic [2:0]               st_slot;
    logic [DW-1:0]            rd_idx, rd_deg;
    logic signed [DATA_W-1:0] rd_coef;
    logic [NUM_POLY-1:0]      valid;

    // Invalidation happens at command accept, before slot_r is loaded.
    assign st_slot  = (state == S_IDLE) ? arg1 : slot_r;
    assign rd_idx   = (state == S_HORNER) ? k_r - DW'(1) : rd_deg;
    assign x_ext    = ACC_W'(x_r);
    assign coef_ext = ACC_W'(rd_coef);
    assign out_data = (state == S_EMIT) ? acc_r : '0;
    assign status   = st_r;

    poly_coef_store #(
        .DATA_W  (DATA_W),
        .MAX_DEG (MAX_DEG),
        .NUM_POLY(NUM_POLY)
    ) u_store (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .set_valid(set_valid),
        .inval_en (inval_en),
        .clr_all  (clr_all),
        .slot     (st_slot),
        .wr_idx   (k_r),
        .wr_data  (in_data),
        .set_deg  (deg_r),
        .rd_slot  (slot_r),
        .rd_idx   (rd_idx),
        .rd_coef  (rd_coef),
        .rd_deg   (rd_deg),
        .valid    (valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        st_nxt       = st_r;
        wr_en        = 1'b0;
        set_valid    = 1'b0;
        inval_en     = 1'b0;
        clr_all      = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        done_proc    = 1'b0;
        status_valid = 1'b0;
        busy         = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_proc) begin
                    state_nxt = S_DONE;
                    st_nxt    = ST_OK;
                    if (error_in != 2'd0) begin
                        st_nxt = error_in;
                    end else begin
                        case (command)
                            OP_SET: begin
                                if (int'(arg2) > MAX_DEG) begin
                                    st_nxt = ST_BAD_DEG;
                                end else begin
                                    inval_en  = 1'b1;
                                    state_nxt = S_LOAD;
                                end
                            end
                            OP_EVAL, OP_EVAL_BLK: begin
                                if (!valid[arg1])
                                    st_nxt = ST_NO_POLY;
                                else if (command == OP_EVAL || arg2 != '0)
                                    state_nxt = S_GET_X;
                            end
                            OP_CLR:  clr_all = 1'b1;
                            default: st_nxt = ST_BAD_OP;
                        endcase
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (k_r == '0) begin
                        set_valid = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
            S_GET_X: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (rd_deg == '0) ? S_EMIT : S_HORNER;
            end
            S_HORNER: begin
                if (k_r == DW'(1))
                    state_nxt = S_EMIT;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = (cnt_r == 5'd1) ? S_DONE : S_GET_X;
            end
            S_DONE: begin
                done_proc    = 1'b1;
                status_valid = 1'b1;
                state_nxt    = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_r <= '0;
            deg_r  <= '0;
            k_r    <= '0;
            cnt_r  <= '0;
            x_r    <= '0;
            acc_r  <= '0;
            st_r   <= ST_OK;
        end else begin
            st_r <= st_nxt;
            case (state)
                S_IDLE: begin
                    if (start_proc) begin
                        slot_r <= arg1;
                        deg_r  <= DW'(arg2);
                        k_r    <= DW'(arg2);
                        cnt_r  <= (command == OP_EVAL_BLK) ? arg2 : 5'd1;
                    end
                end
                S_LOAD: begin
                    if (in_valid)
                        k_r <= k_r - DW'(1);
                end
                S_GET_X: begin
                    if (in_valid) begin
                        x_r   <= in_data;
                        acc_r <= coef_ext;
                        k_r   <= rd_deg;
                    end
                end
                S_HORNER: begin
                    k_r   <= k_r - DW'(1);
                    acc_r <= acc_r * x_ext + coef_ext;
                end
                S_EMIT: begin
                    if (out_ready)
                        cnt_r <= cnt_r - 5'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_cmd_exec.sv
// Directed bench for poly_cmd_exec against a power-sum polynomial model.
module tb_poly_cmd_exec;

    logic               clk;
    logic               reset;
    logic               start_proc;
    logic [7:0]         command;
    logic [2:0]         arg1;
    logic [4:0]         arg2;
    logic [1:0]         error_in;
    logic signed [15:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic [1:0]         status;
    logic               status_valid;
    logic               done_proc;
    logic               busy;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  n_xfer = 0;
    int  last_out = 0;
    int  out_log[$];
    int  exp_q[$];
    int  exp_st_q[$];
    int  vals[$];
    bit  in_allowed = 0;

    int        mcoef [8][11];
    int        mdeg  [8];
    bit [7:0]  mvalid = '0;

    poly_cmd_exec #(
        .DATA_W  (16),
        .ACC_W   (32),
        .MAX_DEG (10),
        .NUM_POLY(8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_proc  (start_proc),
        .command     (command),
        .arg1        (arg1),
        .arg2        (arg2),
        .error_in    (error_in),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .status      (status),
        .status_valid(status_valid),
        .done_proc   (done_proc),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Sum of c[j]*x^j with 32-bit wrap; equal to Horner modulo 2^32.
    function automatic int model_eval(input int s, input int x);
        int sum, pw;
        sum = 0;
        pw  = 1;
        for (int j = 0; j <= mdeg[s]; j++) begin
            sum += mcoef[s][j] * pw;
            pw  *= x;
        end
        return sum;
    endfunction

    // Compare process: every cycle, half a clock away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("out_valid_spurious", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    if (out_ready) begin
                        last_out = out_data;
                        out_log.push_back(out_data);
                        void'(exp_q.pop_front());
                        n_xfer++;
                    end
                end
            end
            if (done_proc || status_valid) begin
                chk("status_valid", status_valid, 1);
                chk("done_proc", done_proc, 1);
                chk("busy_in_done", busy, 1);
                if (exp_st_q.size() == 0)
                    chk("done_spurious", done_proc, 0);
                else
                    chk("status", status, exp_st_q.pop_front());
            end
            if (!in_allowed)
                chk("in_ready_unexpected", in_ready, 0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_status_valid"}, status_valid, 0);
        chk({tag, "_done_proc"}, done_proc, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_status"}, status, 0);
        chk({tag, "_out_data"}, out_data, 0);
    endtask

    // Called at a negedge; returns at the negedge after the word was taken.
    task automatic send_word(input int w);
        int n;
        n = 0;
        in_data  = 16'(w);
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200)
            chk("in_ready_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_cmd(input int cmd, input int a1, input int a2, input int err, input int bp);
        int  st, n, lat, cnt, x0;
        bit  consume;
        consume = 0;
        cnt     = 0;
        if (err != 0) begin
            st = err;
        end else if (cmd == 0) begin
            if (a2 > 10) st = 2;
            else begin
                st = 0;
                consume = 1;
                mvalid[a1] = 1'b0;
            end
        end else if (cmd == 1 || cmd == 2) begin
            cnt = (cmd == 1) ? 1 : a2;
            if (!mvalid[a1]) begin
                st  = 3;
                cnt = 0;
            end else begin
                st = 0;
                consume = (cnt != 0);
            end
        end else if (cmd == 3) begin
            st = 0;
            mvalid = '0;
        end else begin
            st = 1;
        end
        exp_st_q.push_back(st);
        x0 = n_xfer;
        in_allowed = consume;
        if (bp > 0) out_ready = 1'b0;
        start_proc = 1'b1;
        command    = 8'(cmd);
        arg1       = 3'(a1);
        arg2       = 5'(a2);
        error_in   = 2'(err);
        @(negedge clk);
        start_proc = 1'b0;
        error_in   = 2'd0;
        if (!consume) begin
            chk("done_next_cycle", done_proc, 1);
        end else if (cmd == 0) begin
            for (int j = 0; j <= a2; j++) begin
                send_word(vals[j]);
                mcoef[a1][a2-j] = vals[j];
            end
            mdeg[a1] = a2;
        end else begin
            for (int j = 0; j < cnt; j++) begin
                exp_q.push_back(model_eval(a1, vals[j]));
                send_word(vals[j]);
                lat = 1;
                while (!out_valid && lat < 40) begin
                    @(negedge clk);
                    lat++;
                end
                chk("x_to_out_latency", lat, mdeg[a1] + 1);
                if (bp > 0) begin
                    for (int k = 0; k < bp; k++) begin
                        chk("bp_valid_held", out_valid, 1);
                        chk("bp_no_input", in_ready, 0);
                        @(negedge clk);
                    end
                    out_ready = 1'b1;
                end
            end
        end
        n = 0;
        while (!done_proc && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100)
            chk("done_timeout", 0, 1);
        if (consume && cmd == 0)
            mvalid[a1] = 1'b1;
        chk("xfer_count", n_xfer - x0, cnt);
        @(negedge clk);
        in_allowed = 0;
    endtask

    initial begin
        int sz;
        reset      = 1'b0;
        start_proc = 1'b0;
        command    = '0;
        arg1       = '0;
        arg2       = '0;
        error_in   = '0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b1;
        @(negedge clk);

        vals = '{3, 2, 1};
        run_cmd(0, 2, 2, 0, 0);
        chk("model_pin_17", model_eval(2, 2), 17);

        vals = '{2};
        run_cmd(1, 2, 0, 0, 0);
        chk("eval_result_17", last_out, 17);

        run_cmd(1, 5, 0, 0, 0);

        vals = '{0, 1, -1};
        run_cmd(2, 2, 3, 0, 0);
        sz = out_log.size();
        chk("blk_out0", out_log[sz-3], 1);
        chk("blk_out1", out_log[sz-2], 6);
        chk("blk_out2", out_log[sz-1], 2);

        vals = '{3};
        run_cmd(1, 2, 0, 0, 5);
        chk("bp_result", last_out, 34);

        vals = '{-5};
        run_cmd(0, 0, 0, 0, 0);
        vals = '{100};
        run_cmd(1, 0, 0, 0, 0);
        chk("deg0_result", last_out, -5);

        run_cmd(2, 2, 0, 0, 0);
        run_cmd(7, 1, 0, 1, 0);
        run_cmd(0, 1, 12, 2, 0);

        vals = '{4, -3};
        run_cmd(0, 2, 1, 0, 0);
        vals = '{5};
        run_cmd(1, 2, 0, 0, 0);
        chk("reload_result", last_out, 17);

        run_cmd(3, 0, 0, 0, 0);
        run_cmd(1, 2, 0, 0, 0);

        vals = '{3, 2, 1};
        run_cmd(0, 2, 2, 0, 0);
        vals = '{1200, -3000, 32767, -32768, 5, -7, 11, 13, -17, 19, 23};
        run_cmd(0, 3, 10, 0, 0);
        vals = '{7, -9};
        run_cmd(2, 3, 2, 0, 0);

        // Abort a degree-10 evaluation partway through its Horner steps.
        in_allowed = 1;
        start_proc = 1'b1;
        command    = 8'd1;
        arg1       = 3'd3;
        arg2       = 5'd0;
        @(negedge clk);
        start_proc = 1'b0;
        chk("abort_x_ready", in_ready, 1);
        in_data  = -16'sd2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", busy, 1);
        chk("abort_no_out", out_valid, 0);
        in_allowed = 0;
        reset = 1'b0;
        #2;
        check_reset_outputs("midrst");
        mvalid = '0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_cmd(1, 2, 0, 0, 0);

        repeat (3) @(negedge clk);
        chk("exp_out_drained", exp_q.size(), 0);
        chk("exp_status_drained", exp_st_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/poly_cmd_exec.md
Name: poly_cmd_exec

Overview:
- Command execution stage directly downstream of the command fetch/decode FSM.
- Accepts one decoded command (opcode, arg1, arg2, decode error) per start pulse.
- Loads polynomial coefficients from the input data stream, or evaluates a stored polynomial by Horner's rule and streams results out.
- Reports a status code per command, then signals done so the fetch stage can read the next command.

Parameters:
- DATA_W, 16, signed width of coefficients and x values on in_data.
- ACC_W, 32, signed width of the Horner accumulator and out_data.
- MAX_DEG, 10, maximum polynomial degree accepted.
- NUM_POLY, 8, number of polynomial slots; indexed by arg1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-low.
- start_proc  input  1  one-cycle pulse; command/arg1/arg2/error_in are valid this cycle.
- command  input  8  opcode: 0=SET, 1=EVAL, 2=EVAL_BLK, 3=CLR.
- arg1  input  3  polynomial slot.
- arg2  input  5  degree (SET) or x count (EVAL_BLK).
- error_in  input  2  decode error from upstream; 0=none, 1=bad opcode, 2=degree>MAX_DEG.
- in_data  input  DATA_W  coefficient or x value.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block consumes in_data when in_valid&&in_ready.
- out_data  output  ACC_W  evaluation result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when out_valid&&out_ready.
- status  output  2  0=ok, 1=bad opcode, 2=bad degree, 3=slot not loaded.
- status_valid  output  1  one-cycle pulse, coincident with done_proc.
- done_proc  output  1  one-cycle pulse ending every command.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - Outputs: in_ready, out_valid, status_valid, done_proc, busy = 0; status = 0; out_data = 0.
  - State: all slot valid bits cleared; state=IDLE.
  - Coefficient contents need not reset.
- States: IDLE, LOAD, GET_X, HORNER, EMIT, DONE.
- IDLE:
  - start_proc latches command/args/error_in.
  - If error_in≠0: go to DONE with status=error_in; consume no input.
  - SET: deg=arg2, k=deg → LOAD.
  - EVAL: slot valid → GET_X with count=1; slot invalid → DONE with status=3.
  - EVAL_BLK: slot invalid → status 3. arg2=0 → DONE with status 0. Otherwise GET_X with count=arg2.
  - CLR: clear all valid bits → DONE with status 0.
  - start_proc while busy is ignored.
- LOAD:
  - in_ready=1; each accepted word is written as coef[slot][k], k decrementing. Highest-order coefficient arrives first.
  - After coef[slot][0] is accepted: set valid[slot], store deg[slot] → DONE.
  - A partially loaded slot has valid=0. Reloading clears valid at LOAD entry.
- GET_X:
  - in_ready=1; on accept latch x, acc=sext(coef[slot][deg]), i=deg.
  - i=0 → EMIT; else → HORNER.
- HORNER:
  - One step per cycle: i=i-1, acc = acc*sext(x) + sext(coef[slot][i]), truncated to the low ACC_W bits (two's-complement wrap, no saturation).
  - Exit to EMIT when i reaches 0. Latency from x accept to out_valid = deg+1 cycles.
- EMIT:
  - out_valid=1, out_data=acc, held stable until out_ready.
  - On handshake: count-1; if count>0 → GET_X, else → DONE.
  - A same-cycle handshake drops out_valid next cycle.
- DONE: done_proc=1 and status_valid=1 for one cycle → IDLE.
- in_ready is 0 outside LOAD and GET_X. out_valid is 0 outside EMIT.
- Reset asserted mid-command: immediate return to IDLE with all slots invalid. No partial output or status is produced.

Decomposition:
- Shared package poly_pkg holds:
  - opcode constants OP_SET/OP_EVAL/OP_EVAL_BLK/OP_CLR;
  - status constants ST_OK/ST_BAD_OP/ST_BAD_DEG/ST_NO_POLY;
  - state encoding;
  - MAX_DEG and NUM_POLY, also used by the decode stage.
- Sub-module poly_coef_store:
  - NUM_POLY×(MAX_DEG+1) coefficient register file;
  - per-slot degree and valid bits;
  - one write port, one combinational read port, global clear.

Test Plan:
- SET slot 2, arg2=2, stream 3,2,1; then EVAL slot 2, x=2 → out_data=17, status=0; out_valid 3 cycles after x accept.
- EVAL slot 5 with slot 5 never loaded → no input consumed, no out_valid, status=3 with done_proc.
- EVAL_BLK slot 2, arg2=3, x=0,1,-1 → outputs 1, 6, 2 in order, then one done_proc.
- Backpressure: out_ready low 5 cycles during EMIT → out_data/out_valid stable, no extra in_data consumed; release → single transfer.
- start_proc with error_in=2 → status=2, done_proc next cycle, in_ready never high. CLR then EVAL slot 2 → status 3.
- Assert reset during HORNER of a degree-10 evaluation → outputs at reset values. Subsequent EVAL slot 2 → status 3.
